multicycle_sequencer: RTL

Multi-cycle control FSM for the single-issue RV32I core. It sequences fetch, decode, execute, memory and writeback around the combinational instruction decoder, and shares the one memory port between instruction fetch and load/store. It drives instruction-register, PC, ALU-latch and register-file enables from the decoded instruction class, and faults on a memory-handshake timeout.

---
 rtl/multicycle_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback,
// shares the single memory port between fetch and load/store, and faults on a stalled handshake.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_branch,
    input  logic        dec_wb,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        alu_latch,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        rf_sel_mem,
    output logic        retired,
    output logic [31:0] instret,
    output logic [2:0]  state,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd7
    } state_t;

    // Memory handshake: a request is held (mem_req=1) until mem_ready is seen in the same cycle;
    // that cycle completes the transfer and the FSM moves on at the next rising edge.

    localparam bit                   TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST  =
        (MEM_TIMEOUT == 0) ? '0 : TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_t               state_q;
    state_t               state_d;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 taken_q;
    logic                 timeout_hit;
    state_t               boundary;

    // The last permitted stall cycle still honours mem_ready; only a miss there faults.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !mem_ready;
    assign boundary    = run ? S_FETCH : S_IDLE;
    assign state       = state_q;

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        alu_latch    = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        rf_sel_mem   = 1'b0;
        retired      = 1'b0;
        fault        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_latch = 1'b1;
                if (dec_load && dec_store)      state_d = S_FAULT;
                else if (dec_load || dec_store) state_d = S_MEMORY;
                else                            state_d = S_WRITEBACK;
            end
            S_MEMORY: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = dec_store;
                if (mem_ready) begin
                    // Stores have nothing to write back, so they retire on the memory cycle.
                    if (dec_store) begin
                        pc_we   = 1'b1;
                        retired = 1'b1;
                        state_d = boundary;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                rf_we      = dec_wb;
                rf_sel_mem = dec_load;
                pc_we      = 1'b1;
                pc_sel     = taken_q;
                retired    = 1'b1;
                state_d    = boundary;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            taken_q  <= 1'b0;
            instret  <= 32'd0;
        end else begin
            state_q <= state_d;
            // Any state change clears the counter, which covers entry into FETCH and MEMORY.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_q == S_EXECUTE) taken_q <= dec_branch & branch_taken;
            if (retired) instret <= instret + 32'd1;
        end
    end

endmodule
